uart_msg_sequencer: RTL and testbench

- Controller that sequences a stored character string out of the synchronous character ROM into the UART transmit FIFO write port.
- On a start request it fetches bytes base_addr..base_addr+msg_len-1.
- Each byte is written when the FIFO has room, honouring tx_full backpressure.
- Optionally appends CR LF.
- Sits between user logic (button/counter-driven message select) and the uart block's w_data/wr_uart/tx_full interface.

---
 rtl/uart_msg_sequencer_if.sv | 23 ++
 rtl/uart_msg_sequencer.sv | 124 ++++++++++++
 tb/tb_uart_msg_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_msg_sequencer_if.sv
// Handshake bundle between the message sequencer, the synchronous
// character ROM and the UART transmit FIFO write port.
interface uart_msg_sequencer_if #(
  parameter int ADDR_BITS = 8
);
  logic [ADDR_BITS-1:0] rom_addr;  // registered ROM address
  logic [7:0]           rom_data;  // ROM byte, valid one clk after rom_addr
  logic                 tx_full;   // UART TX FIFO full flag
  logic [7:0]           w_data;    // byte presented to the FIFO
  logic                 wr_uart;   // FIFO write strobe

  // Sequencer side.
  modport master (
    output rom_addr, w_data, wr_uart,
    input  rom_data, tx_full
  );

  // ROM / UART side.
  modport slave (
    input  rom_addr, w_data, wr_uart,
    output rom_data, tx_full
  );
endinterface

// File: rtl/uart_msg_sequencer.sv
// Streams a stored string out of a synchronous character ROM into the
// UART TX FIFO, one byte per FIFO slot, optionally followed by CR LF.
// ROM bytes cost two clocks (fetch + write), terminator bytes one clock.
module uart_msg_sequencer #(
  parameter int ADDR_BITS   = 8,
  parameter int LEN_BITS    = 5,
  parameter bit APPEND_CRLF = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [LEN_BITS-1:0]  msg_len,
  output logic                 busy,
  output logic                 done,
  uart_msg_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WRITE,
    S_CR,
    S_LF,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [LEN_BITS-1:0]  r_idx;
  logic [LEN_BITS-1:0]  r_len;
  logic [ADDR_BITS-1:0] r_base;
  logic [ADDR_BITS-1:0] r_rom_addr;
  logic [7:0]           r_w_hold;   // last byte shown on w_data
  logic [7:0]           w_byte;
  logic                 w_wr;
  logic                 w_last;
  logic                 w_accept;

  assign w_accept = (r_state == S_IDLE) && start;
  // r_len is never zero while in WRITE, so len-1 cannot underflow there.
  assign w_last   = (r_idx == r_len - LEN_BITS'(1));

  // Next-state, write strobe and outgoing byte selection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    w_next_state = r_state;
    w_wr         = 1'b0;
    w_byte       = r_w_hold;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (msg_len != '0)    w_next_state = S_FETCH;
          else if (APPEND_CRLF) w_next_state = S_CR;
          else                  w_next_state = S_DONE;
        end
      end
      S_FETCH: w_next_state = S_WRITE;
      S_WRITE: begin
        w_byte = bus.rom_data;
        w_wr   = ~bus.tx_full & ~abort;
        if (w_wr) begin
          if (!w_last)          w_next_state = S_FETCH;
          else if (APPEND_CRLF) w_next_state = S_CR;
          else                  w_next_state = S_DONE;
        end
      end
      S_CR: begin
        w_byte = 8'h0D;
        w_wr   = ~bus.tx_full & ~abort;
        if (w_wr) w_next_state = S_LF;
      end
      S_LF: begin
        w_byte = 8'h0A;
        w_wr   = ~bus.tx_full & ~abort;
        if (w_wr) w_next_state = S_DONE;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    // Abort wins over everything except in IDLE, where it is ignored.
    if (abort && r_state != S_IDLE) w_next_state = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments for all clocked state, so every
    // register samples pre-edge values regardless of block order.
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Message bookkeeping: latch the request, advance index and ROM address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base     <= '0;
      r_len      <= '0;
      r_idx      <= '0;
      r_rom_addr <= '0;
      r_w_hold   <= '0;
    end else begin
      if (w_accept) begin
        r_base     <= base_addr;
        r_len      <= msg_len;
        r_idx      <= '0;
        r_rom_addr <= base_addr;
      end else if (r_state == S_WRITE && w_wr && !w_last) begin
        r_idx      <= r_idx + LEN_BITS'(1);
        r_rom_addr <= r_base + ADDR_BITS'(r_idx) + ADDR_BITS'(1);
      end
      if (r_state == S_WRITE || r_state == S_CR || r_state == S_LF)
        r_w_hold <= w_byte;
    end
  end

  assign bus.rom_addr = r_rom_addr;
  assign bus.w_data   = w_byte;
  assign bus.wr_uart  = w_wr;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// Bench for uart_msg_sequencer: two instances (with and without CR LF)
// share stimulus; a cycle schedule is derived from the byte list, the
// FIFO-full pattern and the latency/throughput rules, then compared
// cycle by cycle against both instances.
module tb_uart_msg_sequencer;

  localparam int NC = 512;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] base_addr;
  logic [4:0] msg_len;
  logic       tx_full;
  logic       busy0, done0, busy1, done1;

  logic [7:0] rom [256];
  bit         mask [NC];

  // Expected per-cycle behaviour, index [dut][cycle relative to start].
  bit         ewr   [2][NC];
  bit         ebusy [2][NC];
  bit         edone [2][NC];
  bit         edv   [2][NC];
  bit         eav   [2][NC];
  logic [7:0] edata [2][NC];
  logic [7:0] eaddr [2][NC];
  int         end_rel [2];

  int errors = 0;
  int checks = 0;

  uart_msg_sequencer_if #(.ADDR_BITS(8)) bus0 ();
  uart_msg_sequencer_if #(.ADDR_BITS(8)) bus1 ();

  uart_msg_sequencer #(.ADDR_BITS(8), .LEN_BITS(5), .APPEND_CRLF(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .msg_len(msg_len),
    .busy(busy0), .done(done0), .bus(bus0)
  );

  uart_msg_sequencer #(.ADDR_BITS(8), .LEN_BITS(5), .APPEND_CRLF(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .msg_len(msg_len),
    .busy(busy1), .done(done1), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Synchronous character ROMs.
  always @(posedge clk) bus0.rom_data <= rom[bus0.rom_addr];
  always @(posedge clk) bus1.rom_data <= rom[bus1.rom_addr];
  assign bus0.tx_full = tx_full;
  assign bus1.tx_full = tx_full;

  logic       owr   [2];
  logic       obusy [2];
  logic       odone [2];
  logic [7:0] odata [2];
  logic [7:0] oaddr [2];
  assign owr[0] = bus0.wr_uart;  assign owr[1] = bus1.wr_uart;
  assign obusy[0] = busy0;       assign obusy[1] = busy1;
  assign odone[0] = done0;       assign odone[1] = done1;
  assign odata[0] = bus0.w_data; assign odata[1] = bus1.w_data;
  assign oaddr[0] = bus0.rom_addr; assign oaddr[1] = bus1.rom_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Byte list -> cycle schedule. A ROM byte spends one fetch cycle then
  // waits in its write slot until the FIFO has room; CR/LF have only the
  // write slot. done follows the last write by one cycle. An abort at
  // cycle a suppresses writes from a on and ends the message.
  task automatic build_model(input int d, input bit crlf, input int b,
                             input int l, input int a);
    int p, ws, t, nb, ab, last;
    logic [7:0] by;
    ab = (a <= 0) ? 100000 : a;
    for (int c = 0; c < NC; c++) begin
      ewr[d][c] = 0; ebusy[d][c] = 0; edone[d][c] = 0;
      edv[d][c] = 0; eav[d][c] = 0; edata[d][c] = '0; eaddr[d][c] = '0;
    end
    nb = l + (crlf ? 2 : 0);
    p  = 1;
    for (int k = 0; k < nb; k++) begin
      if (k < l)       by = rom[8'(b + k)];
      else if (k == l) by = 8'h0D;
      else             by = 8'h0A;
      ws = (k < l) ? p + 1 : p;
      t  = ws;
      while (mask[t]) t++;
      for (int c = p; c <= t; c++) begin
        if (k < l && c <= ab) begin eav[d][c] = 1; eaddr[d][c] = 8'(b + k); end
        if (c >= ws && c <= ab) begin edv[d][c] = 1; edata[d][c] = by; end
      end
      if (t < ab) ewr[d][t] = 1;
      p = t + 1;
    end
    last = (ab < p) ? ab : p;
    for (int c = 1; c <= last; c++) ebusy[d][c] = 1;
    if (p <= ab) edone[d][p] = 1;
    end_rel[d] = last;
  endtask

  task automatic clear_mask();
    for (int i = 0; i < NC; i++) mask[i] = 0;
  endtask

  // One message: start at rel 0, optional abort at rel a (a<0: none,
  // a==0: together with start), optional ignored re-start at rel rs.
  task automatic run_msg(input string name, input int b, input int l,
                         input int a, input int rs);
    int last;
    build_model(0, 1'b0, b, l, a);
    build_model(1, 1'b1, b, l, a);
    last = ((end_rel[0] > end_rel[1]) ? end_rel[0] : end_rel[1]) + 2;
    for (int rel = 0; rel <= last; rel++) begin
      start = (rel == 0) || (rel == rs);
      if (rel == 0) begin
        base_addr = 8'(b); msg_len = 5'(l);
      end else if (rel == rs) begin
        base_addr = 8'($urandom); msg_len = 5'($urandom);
      end
      abort   = (rel == a);
      tx_full = mask[rel];
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("%s d%0d r%0d wr", name, d, rel), 32'(owr[d]), 32'(ewr[d][rel]));
        check($sformatf("%s d%0d r%0d busy", name, d, rel), 32'(obusy[d]), 32'(ebusy[d][rel]));
        check($sformatf("%s d%0d r%0d done", name, d, rel), 32'(odone[d]), 32'(edone[d][rel]));
        if (edv[d][rel])
          check($sformatf("%s d%0d r%0d w_data", name, d, rel), 32'(odata[d]), 32'(edata[d][rel]));
        if (eav[d][rel])
          check($sformatf("%s d%0d r%0d rom_addr", name, d, rel), 32'(oaddr[d]), 32'(eaddr[d][rel]));
      end
      @(posedge clk); #1;
    end
    start = 0; abort = 0; tx_full = 0;
  endtask

  // Asynchronous reset landing in the WRITE cycle of the second byte.
  task automatic reset_mid();
    base_addr = 8'h10; msg_len = 5'd3; start = 1;
    @(posedge clk); #1; start = 0;
    repeat (3) begin @(posedge clk); #1; end
    #2; reset = 1; #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst d%0d wr", d), 32'(owr[d]), 32'd0);
      check($sformatf("rst d%0d busy", d), 32'(obusy[d]), 32'd0);
      check($sformatf("rst d%0d done", d), 32'(odone[d]), 32'd0);
      check($sformatf("rst d%0d w_data", d), 32'(odata[d]), 32'd0);
      check($sformatf("rst d%0d rom_addr", d), 32'(oaddr[d]), 32'd0);
    end
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("post-rst d%0d busy", d), 32'(obusy[d]), 32'd0);
      check($sformatf("post-rst d%0d wr", d), 32'(owr[d]), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int b, l, a;
    reset = 1; start = 0; abort = 0; tx_full = 0;
    base_addr = '0; msg_len = '0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h10] = 8'h41; rom[8'h11] = 8'h42; rom[8'h12] = 8'h43;
    clear_mask();

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset d%0d busy", d), 32'(obusy[d]), 32'd0);
      check($sformatf("reset d%0d done", d), 32'(odone[d]), 32'd0);
      check($sformatf("reset d%0d wr", d), 32'(owr[d]), 32'd0);
      check($sformatf("reset d%0d w_data", d), 32'(odata[d]), 32'd0);
      check($sformatf("reset d%0d rom_addr", d), 32'(oaddr[d]), 32'd0);
    end
    @(posedge clk); #1; reset = 0;
    @(posedge clk); #1;

    run_msg("basic", 8'h10, 3, -1, -1);

    for (int i = 4; i <= 8; i++) mask[i] = 1;
    run_msg("bp", 8'h10, 3, -1, -1);
    clear_mask();

    run_msg("zero", 8'h33, 0, -1, -1);
    run_msg("wrap", 8'hFE, 4, -1, -1);
    run_msg("max", 8'hE8, 31, -1, -1);

    run_msg("abort", 8'h10, 3, 4, -1);
    run_msg("after-abort", 8'h10, 3, -1, -1);
    run_msg("abort-idle", 8'h20, 2, 0, -1);
    run_msg("restart", 8'h10, 3, -1, 2);

    reset_mid();
    run_msg("after-rst", 8'h10, 3, -1, -1);

    for (int n = 0; n < 24; n++) begin
      b = int'($urandom_range(0, 255));
      l = int'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * l + 4)) : -1;
      for (int i = 0; i < NC; i++) mask[i] = (i < 120) && ($urandom_range(0, 2) == 0);
      run_msg($sformatf("rnd%0d", n), b, l, a, -1);
    end
    clear_mask();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
